comp_event_unit: RTL
====================

// Module: comp_event_unit
// PURPOSE
//  Downstream of the comparator unit. Takes its raw low/high threshold strobes and data-update pulse,
//  qualifies each over N consecutive decimated samples, and latches sticky low/high flags.
//  Flags clear by software write-1 pulse or by hardware auto-clear. Combines flags with enables into one
//  interrupt to the register/interrupt block. All logic on SYSCLK; comparator strobes are resynchronised here.
// PARAMETERS
//  FCNT_W   4   width of qualification count (N = 1..2^FCNT_W-1)
// PORTS
//  SYSCLK            in   1        system clock; only clock
//  SYSRSTn           in   1        asynchronous active-low reset
//  comp_data_update  in   1        1-cycle SYSCLK pulse: new comparator sample valid
//  comp_data_low     in   1        raw data<low threshold strobe (sd_clk-related, async to SYSCLK)
//  comp_data_high    in   1        raw data>=high threshold strobe (async to SYSCLK)
//  reg_compen        in   1        comparator enable
//  reg_compfcnt      in   FCNT_W   consecutive samples required to trip; 0 treated as 1
//  reg_compilen      in   1        interrupt enable, low flag
//  reg_compihen      in   1        interrupt enable, high flag
//  reg_complclrflg   in   1        hardware auto-clear enable, low flag
//  reg_comphclrflg   in   1        hardware auto-clear enable, high flag
//  flg_clr_low       in   1        software clear pulse, low flag
//  flg_clr_high      in   1        software clear pulse, high flag
//  comp_flg_low      out  1        sticky low flag
//  comp_flg_high     out  1        sticky high flag
//  comp_evt_low      out  1        1-cycle pulse when low channel trips
//  comp_evt_high     out  1        1-cycle pulse when high channel trips
//  comp_int          out  1        registered interrupt level
// BEHAVIOUR
//  Reset: all outputs, synchronisers, counters = 0; both FSMs IDLE. Reset mid-operation aborts any count.
//  Sync: each raw strobe -> 2-flop synchroniser; s_low/s_high = 2nd stage, sampled only when comp_data_update=1.
//  Per-channel FSM and counter cnt[FCNT_W-1:0]; n = (reg_compfcnt==0) ? 1 : reg_compfcnt.
//  FSM advances only on an update cycle with reg_compen=1:
//   IDLE: s=1 -> cnt=1; if n==1 -> TRIP, else QUAL.  s=0 -> stay, cnt=0.
//   QUAL: s=1 -> cnt+1; if cnt+1==n -> TRIP.  s=0 -> IDLE, cnt=0.
//   TRIP: s=1 -> stay; cnt saturates at n.  s=0 -> IDLE, cnt=0.
//  On entry to TRIP, comp_evt_* pulses for exactly 1 cycle after the update edge.
//   Also on entry, comp_flg_* sets at that edge.
//  A run held in TRIP gives one event only; the next event needs a release (s=0) and a new run.
//  reg_compfcnt changed mid-count: compare against the new value. If cnt>=n in QUAL, trip on the next s=1.
//  reg_compen=0: FSMs forced IDLE, cnt=0, no events. Flags hold and stay software-clearable.
//  Flag clear:
//   flg_clr_* =1 clears the flag next cycle.
//   Hardware clear (reg_c*clrflg=1): flag clears on the TRIP->IDLE update edge.
//   Set and clear in the same cycle: set wins, flag = 1.
//  comp_int <= (comp_flg_low & reg_compilen) | (comp_flg_high & reg_compihen); one cycle after the flag.
//  Low and high channels are independent; both may trip on the same update.
//  Latency:
//   raw strobe -> s_*: 2 SYSCLK.
//   Qualifying update cycle -> flag/evt: 1 SYSCLK.
//   Qualifying update cycle -> comp_int: 2 SYSCLK.
//  Non-update cycles: FSMs, cnt, flags hold, except for flag clears.
//  Widths: cnt compare is unsigned FCNT_W bits; no wrap, because cnt saturates at n.
// TESTING
//  T1 fcnt=0, compen=1, ilen=1: one update with low=1 -> evt_low 1 pulse, flg_low=1 next cycle, comp_int=1 cycle after.
//  T2 fcnt=3: high=1 for 2 updates, then 0, then 3 updates -> no trip after 2; trip on the 3rd of the second run; exactly one evt.
//  T3 hclrflg=1, fcnt=1: high trips, then update with high=0 -> flg_high clears same edge FSM goes IDLE; hclrflg=0 -> flag stays.
//  T4 flg_clr_low asserted in the same cycle as a trip -> flg_low remains 1.
//   A lone flg_clr_low -> flg_low=0 next cycle; comp_int drops 1 cycle later.
//  T5 fcnt=4, 2 qualified updates, compen->0 -> cnt=0, IDLE, no evt; compen->1 and 4 updates -> trip.
//  T6 SYSRSTn low mid-QUAL with flags set -> all outputs 0 immediately (async).
//   Release, then low held 1 with no update pulses -> no flag.

Source files
------------

// File: rtl/comp_event_unit.sv
// Comparator event qualifier: resynchronises the raw low/high threshold strobes, qualifies each over
// N consecutive updates, and produces sticky flags, one-shot events and a combined interrupt.
module comp_event_unit #(
    parameter int FCNT_W = 4
) (
    input  logic              SYSCLK,
    input  logic              SYSRSTn,
    input  logic              comp_data_update,
    input  logic              comp_data_low,
    input  logic              comp_data_high,
    input  logic              reg_compen,
    input  logic [FCNT_W-1:0] reg_compfcnt,
    input  logic              reg_compilen,
    input  logic              reg_compihen,
    input  logic              reg_complclrflg,
    input  logic              reg_comphclrflg,
    input  logic              flg_clr_low,
    input  logic              flg_clr_high,
    output logic              comp_flg_low,
    output logic              comp_flg_high,
    output logic              comp_evt_low,
    output logic              comp_evt_high,
    output logic              comp_int
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        QUAL = 2'd1,
        TRIP = 2'd2
    } state_t;

    localparam logic [FCNT_W-1:0] CNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

    // Channel index 0 is the low threshold, index 1 the high threshold.
    logic [1:0]        raw_v;
    logic [1:0]        sw_clr_v;
    logic [1:0]        hw_clr_en_v;
    logic [1:0]        flg_v;
    logic [1:0]        evt_v;
    logic [FCNT_W-1:0] n;

    assign raw_v       = {comp_data_high, comp_data_low};
    assign sw_clr_v    = {flg_clr_high, flg_clr_low};
    assign hw_clr_en_v = {reg_comphclrflg, reg_complclrflg};

    // A programmed count of zero behaves as a single-sample qualification.
    assign n = (reg_compfcnt == '0) ? CNT_ONE : reg_compfcnt;

    genvar g;
    for (g = 0; g < 2; g++) begin : g_ch
        state_t            state;
        state_t            state_nxt;
        logic              sync_p0;
        logic              sync_p1;
        logic [FCNT_W-1:0] cnt;
        logic [FCNT_W-1:0] cnt_nxt;
        logic [FCNT_W:0]   cnt_inc;
        logic              trip_entry;
        logic              trip_release;
        logic              flg;
        logic              flg_nxt;
        logic              evt;

        // Stage p0/p1: two-flop resynchroniser for the asynchronous strobe
        always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
            if (!SYSRSTn) begin
                sync_p0 <= 1'b0;
                sync_p1 <= 1'b0;
            end else begin
                sync_p0 <= raw_v[g];
                sync_p1 <= sync_p0;
            end
        end

        always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
            if (!SYSRSTn) begin
                state <= IDLE;
                cnt   <= '0;
                flg   <= 1'b0;
                evt   <= 1'b0;
            end else begin
                state <= state_nxt;
                cnt   <= cnt_nxt;
                flg   <= flg_nxt;
                evt   <= trip_entry;
            end
        end

        // One bit wider so a count lowered below cnt mid-run still compares correctly.
        assign cnt_inc = {1'b0, cnt} + {{FCNT_W{1'b0}}, 1'b1};

        always_comb begin
            state_nxt = state;
            cnt_nxt   = cnt;
            if (!reg_compen) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end else if (comp_data_update) begin
                case (state)
                    IDLE: begin
                        if (sync_p1) begin
                            cnt_nxt   = CNT_ONE;
                            state_nxt = (n == CNT_ONE) ? TRIP : QUAL;
                        end else begin
                            cnt_nxt   = '0;
                        end
                    end
                    QUAL: begin
                        if (!sync_p1) begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end else if (cnt_inc >= {1'b0, n}) begin
                            state_nxt = TRIP;
                            cnt_nxt   = n;
                        end else begin
                            cnt_nxt   = cnt_inc[FCNT_W-1:0];
                        end
                    end
                    TRIP: begin
                        if (sync_p1) begin
                            cnt_nxt   = n;
                        end else begin
                            state_nxt = IDLE;
                            cnt_nxt   = '0;
                        end
                    end
                    default: begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end

        assign trip_entry   = (state != TRIP) && (state_nxt == TRIP);
        assign trip_release = reg_compen && comp_data_update && (state == TRIP) && !sync_p1;

        // Setting has priority over both clear sources.
        always_comb begin
            flg_nxt = flg;
            if (trip_entry) begin
                flg_nxt = 1'b1;
            end else if (sw_clr_v[g] || (hw_clr_en_v[g] && trip_release)) begin
                flg_nxt = 1'b0;
            end
        end

        assign flg_v[g] = flg;
        assign evt_v[g] = evt;
    end

    always_ff @(posedge SYSCLK or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            comp_int <= 1'b0;
        end else begin
            comp_int <= (flg_v[0] & reg_compilen) | (flg_v[1] & reg_compihen);
        end
    end

    assign comp_flg_low  = flg_v[0];
    assign comp_flg_high = flg_v[1];
    assign comp_evt_low  = evt_v[0];
    assign comp_evt_high = evt_v[1];

endmodule
